serial_word_assembler: RTL and testbench
========================================

// Module: serial_word_assembler
// PURPOSE
//  Bit-serial to 32-bit parallel assembler: the write-side inverse of the 32:1 bit-select mux.
//  Accepts one bit per valid/ready handshake and demultiplexes it into the word at index k.
//  Uses the same index convention as the mux: index k <-> word bit (WIDTH-1-k), so the stream is MSB-first.
//  Sits between a serial source (shifter/test feed) and the 32-bit ALU operand inputs.
// PARAMETERS
//  WIDTH  32  assembled word width; must equal 2**IDX_W
//  IDX_W  5   width of the bit index counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  flush      in   1      synchronous discard of partial or held word
//  in_valid   in   1      in_bit is valid this cycle
//  in_ready   out  1      assembler can accept a bit
//  in_bit     in   1      serial data bit
//  out_valid  out  1      out_word is complete
//  out_ready  in   1      consumer takes out_word
//  out_word   out  WIDTH  assembled word
//  bit_idx    out  IDX_W  index the next accepted bit will be written to
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=FILL, bit_idx=0, out_word=0, out_valid=0, in_ready=1.
//  - in_ready = (state==FILL); out_valid = (state==HOLD); both are pure decodes of state.
//  - FILL: when in_valid&&in_ready, out_word[WIDTH-1-bit_idx] <= in_bit, bit_idx <= bit_idx+1.
//    Other bits of out_word are untouched (decoder-enabled per-bit write).
//  - On the accept with bit_idx==WIDTH-1: bit_idx wraps to 0, state -> HOLD.
//    out_valid rises in the cycle after that edge (latency 1 from the last accept).
//  - HOLD: in_ready=0, no bits accepted; out_word stable until out_ready.
//    out_valid&&out_ready at edge: state -> FILL, out_word <= 0, bit_idx stays 0.
//  - No same-cycle bypass: a bit offered in the HOLD->FILL handshake cycle is not accepted.
//    Max throughput is one word per WIDTH+1 cycles.
//  - flush=1 (highest synchronous priority, any state): state -> FILL, bit_idx <= 0, out_word <= 0.
//    A concurrent bit accept or out handshake is ignored.
//  - in_valid low: no change; gaps of any length are legal mid-word.
//  - rst_n asserted mid-word or in HOLD: immediate return to reset values; the partial word is lost.
//  - out_word is visible while in FILL but is only meaningful when out_valid=1.
// STRUCTURE
//  - Shared package: WIDTH/IDX_W constants, state encoding (FILL=1'b0, HOLD=1'b1).
//  - Sub-module decoder_5_to_32: index plus enable -> one-hot per-bit write enables.
//    It applies the reversed mapping (idx k -> enable bit WIDTH-1-k); it is the structural dual of the mux.
//  - Top level: state flop, IDX_W counter, WIDTH enable-gated bit flops.
// TESTING
//  1. Release reset -> out_valid=0, in_ready=1, bit_idx=0, out_word=32'h0.
//  2. Stream 32'hA5C30F81 MSB-first, in_valid held 1, out_ready=0
//     -> out_valid=1 one cycle after the 32nd accept, out_word=32'hA5C30F81.
//     Holding out_ready=0 for 3 cycles keeps in_ready=0 and the word stable.
//  3. Same word with in_valid on alternate cycles -> identical out_word; bit_idx advances only on accepts.
//  4. Accept 10 bits, pulse flush, then stream 32'hFFFF0000 -> out_word=32'hFFFF0000 with no stale bits.
//  5. Assert rst_n low asynchronously at bit_idx=17 -> outputs return to reset values without a clock edge;
//     the next streamed 32'h12345678 assembles correctly.
//  6. Back-to-back words with out_ready tied 1 -> out_valid high exactly 1 cycle per word,
//     in_ready low exactly 1 cycle between words, period 33 cycles.

Source files
------------

// File: rtl/serial_word_assembler_pkg.sv
// Shared constants, state encoding and index helper for the serial word assembler.
package serial_word_assembler_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDX_W = 5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Stream index k lands on word bit WIDTH-1-k (MSB-first), matching the read-side mux.
  function automatic logic [IDX_W-1:0] rev_idx(input logic [IDX_W-1:0] k);
    return LAST_IDX - k;
  endfunction

endpackage

// File: rtl/serial_word_assembler_decoder_5_to_32.sv
// Index-plus-enable to one-hot per-bit write enables, with the reversed (MSB-first) mapping.
module decoder_5_to_32
  import serial_word_assembler_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_en_c
);

  always_comb begin
    o_en_c = '0;
    if (i_en) begin
      o_en_c[rev_idx(i_idx)] = 1'b1;
    end
  end

endmodule

// File: rtl/serial_word_assembler.sv
// Bit-serial to WIDTH-bit parallel assembler: one bit per valid/ready handshake, MSB-first.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [IDX_W-1:0] bit_idx
);

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_word;

  logic             w_accept;
  logic [WIDTH-1:0] w_wen;

  assign w_accept = in_valid && (r_state == ST_FILL);

  decoder_5_to_32 u_dec (
    .i_idx  (r_idx),
    .i_en   (w_accept),
    .o_en_c (w_wen)
  );

  // Flush outranks both the bit accept and the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
      r_idx   <= '0;
      r_word  <= '0;
    end else if (flush) begin
      r_state <= ST_FILL;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_word <= (r_word & ~w_wen) | ({WIDTH{in_bit}} & w_wen);
            r_idx  <= r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state <= ST_FILL;
            r_word  <= '0;
            r_idx   <= '0;
          end
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_FILL);
  assign out_valid = (r_state == ST_HOLD);
  assign out_word  = r_word;
  assign bit_idx   = r_idx;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler with a scoreboard of expected words.
module tb_serial_word_assembler;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_bit;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [4:0]  bit_idx;

  int checks;
  int errors;
  logic [31:0] sb_q[$];

  serial_word_assembler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .bit_idx   (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop_check(input string tag);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed out_word %h with empty scoreboard, expected none", tag, out_word);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, out_word, exp);
    end
  endtask

  // Drive nbits of w MSB-first; optional idle cycle between bits.
  task automatic stream(input logic [31:0] w, input int nbits, input bit gaps);
    if (nbits == 32) sb_q.push_back(w);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      chk("bit_idx_pre", 32'(bit_idx), 32'(i));
      in_valid = 1'b1;
      in_bit   = w[31-i];
      if (gaps && (i != nbits - 1)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = ~in_bit;
        chk("bit_idx_gap", 32'(bit_idx), 32'(i + 1));
      end
    end
  endtask

  // One negedge after the final accept: word must be held and valid.
  task automatic complete(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_bit_idx"}, 32'(bit_idx), 32'd0);
    sb_pop_check({tag, "_word"});
  endtask

  // Output handshake with a bit offered in the same cycle, which must be ignored.
  task automatic release_word(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_rel_bit_idx"}, 32'(bit_idx), 32'd0);
    chk({tag, "_rel_word"}, out_word, 32'h0);
  endtask

  initial begin
    logic [31:0] words[3];
    int last_rise;
    int ph;
    logic [31:0] cur;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;

    // 1: reset values
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_bit_idx", 32'(bit_idx), 32'd0);
    chk("rst_word", out_word, 32'h0);

    // 2: continuous stream, then hold with out_ready low
    stream(32'hA5C30F81, 32, 1'b0);
    complete("t2");
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_bit   = k[0];
      @(negedge clk);
      chk("t2_hold_in_ready", 32'(in_ready), 32'd0);
      chk("t2_hold_out_valid", 32'(out_valid), 32'd1);
      chk("t2_hold_word", out_word, 32'hA5C30F81);
      chk("t2_hold_bit_idx", 32'(bit_idx), 32'd0);
    end
    release_word("t2");

    // 3: same word with idle cycles between bits
    stream(32'hA5C30F81, 32, 1'b1);
    complete("t3");
    release_word("t3");

    // 4: partial word flushed with a concurrent offered bit
    stream(32'hFFFFFFFF, 10, 1'b0);
    @(negedge clk);
    chk("t4_pre_flush_idx", 32'(bit_idx), 32'd10);
    chk("t4_pre_flush_word", out_word, 32'hFFC00000);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_flush_idx", 32'(bit_idx), 32'd0);
    chk("t4_flush_word", out_word, 32'h0);
    chk("t4_flush_in_ready", 32'(in_ready), 32'd1);
    stream(32'hFFFF0000, 32, 1'b0);
    complete("t4");
    release_word("t4");

    // 5: asynchronous reset mid-word, checked before any clock edge
    stream(32'hFFFFFFFF, 17, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_idx17", 32'(bit_idx), 32'd17);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_out_valid", 32'(out_valid), 32'd0);
    chk("t5_async_in_ready", 32'(in_ready), 32'd1);
    chk("t5_async_bit_idx", 32'(bit_idx), 32'd0);
    chk("t5_async_word", out_word, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stream(32'h12345678, 32, 1'b0);
    complete("t5");
    release_word("t5");

    // 6: back-to-back words with out_ready tied high, 33-cycle period
    words[0]  = 32'hDEADBEEF;
    words[1]  = 32'h0F0F00FF;
    words[2]  = 32'h80000001;
    last_rise = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 3 * 33; c++) begin
      @(negedge clk);
      ph = c % 33;
      chk("t6_in_ready", 32'(in_ready), (ph != 32) ? 32'd1 : 32'd0);
      chk("t6_out_valid", 32'(out_valid), (ph == 32) ? 32'd1 : 32'd0);
      if (ph == 32) begin
        sb_pop_check("t6_word");
        if (last_rise >= 0) chk("t6_period", 32'(c - last_rise), 32'd33);
        last_rise = c;
      end
      if (ph == 0) sb_q.push_back(words[c / 33]);
      cur      = words[c / 33];
      in_valid = 1'b1;
      in_bit   = (ph < 32) ? cur[31-ph] : 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("t6_end_out_valid", 32'(out_valid), 32'd0);
    chk("t6_end_word", out_word, 32'h0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
